// File: rtl/vga_rx_monitor_if.sv
// rtl/vga_rx_monitor_if.sv - VGA sync/colour inputs and recovered pixel/status outputs of vga_rx_monitor
interface vga_rx_monitor_if;
  logic        h_sync;
  logic        v_sync;
  logic        R;
  logic        G;
  logic        B;
  logic [10:0] x_pix;
  logic [10:0] y_pix;
  logic        pix_valid;
  logic [2:0]  pix_rgb;
  logic        lock;
  logic        err_sticky;
  logic [7:0]  err_cnt;
  logic        frame_done;
  logic [17:0] cnt_r;
  logic [17:0] cnt_g;
  logic [17:0] cnt_b;

  modport master (
    output h_sync, v_sync, R, G, B,
    input  x_pix, y_pix, pix_valid, pix_rgb, lock, err_sticky, err_cnt,
    input  frame_done, cnt_r, cnt_g, cnt_b
  );

  modport slave (
    input  h_sync, v_sync, R, G, B,
    output x_pix, y_pix, pix_valid, pix_rgb, lock, err_sticky, err_cnt,
    output frame_done, cnt_r, cnt_g, cnt_b
  );
endinterface

// File: rtl/vga_rx_monitor.sv
// rtl/vga_rx_monitor.sv - VGA receive monitor: sync lock, pixel coordinates, per-frame colour counts
// Per-frame colour counters are built only when VGA_RX_PIXCNT_EN is defined.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 1040,
  parameter int H_SYNC      = 120,
  parameter int H_ACT_START = 105,
  parameter int H_ACTIVE    = 800,
  parameter int V_TOTAL     = 666,
  parameter int V_SYNC      = 8,
  parameter int V_ACT_START = 23,
  parameter int V_ACTIVE    = 600
) (
  input  logic             clk,
  input  logic             reset,
  vga_rx_monitor_if.slave  bus
);
  localparam logic [1:0]  S_SEARCH = 2'd0;
  localparam logic [1:0]  S_TRACK  = 2'd1;
  localparam logic [1:0]  S_LOCKED = 2'd2;
  localparam logic [10:0] POS_MAX  = 11'h7ff;
  localparam logic [10:0] H_TOT    = 11'(H_TOTAL);
  localparam logic [10:0] H_SYN    = 11'(H_SYNC);
  localparam logic [10:0] H_FIRST  = 11'(H_ACT_START);
  localparam logic [10:0] H_LAST   = 11'(H_ACT_START + H_ACTIVE - 1);
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);
  localparam logic [10:0] V_SYN    = 11'(V_SYNC);
  localparam logic [10:0] V_FIRST  = 11'(V_ACT_START);
  localparam logic [10:0] V_LAST   = 11'(V_ACT_START + V_ACTIVE - 1);

  logic        hs_q, vs_q, hs_qq, vs_qq;
  logic [2:0]  rgb_q;
  logic        hs_rise, vs_rise;
  logic [10:0] h_pos, v_pos, hs_low, vs_low;
  logic [10:0] h_pos_nxt, v_pos_nxt;
  logic [1:0]  state, state_nxt;
  logic        err_line, err_timeout, err_frame, err;
  logic        in_window, valid_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hs_qq <= 1'b1;
      vs_qq <= 1'b1;
      rgb_q <= 3'b000;
    end else begin
      hs_q  <= bus.h_sync;
      vs_q  <= bus.v_sync;
      hs_qq <= hs_q;
      vs_qq <= vs_q;
      rgb_q <= {bus.R, bus.G, bus.B};
    end
  end

  assign hs_rise = hs_q & ~hs_qq;
  assign vs_rise = vs_q & ~vs_qq;

  // *_nxt is the position of the pin cycle captured in rgb_q, so outputs register from it.
  always_comb begin
    h_pos_nxt = h_pos;
    if (hs_rise)                 h_pos_nxt = 11'd1;
    else if (h_pos != POS_MAX)   h_pos_nxt = h_pos + 11'd1;
    v_pos_nxt = v_pos;
    if (vs_rise && hs_rise)                  v_pos_nxt = 11'd1;
    else if (hs_rise && v_pos != POS_MAX)    v_pos_nxt = v_pos + 11'd1;
  end

  assign err_line    = hs_rise && (h_pos != H_TOT || hs_low != H_SYN);
  assign err_timeout = !hs_rise && (h_pos == H_TOT);
  assign err_frame   = vs_rise && (!hs_rise || v_pos != V_TOT || vs_low != V_SYN);
  assign err         = (state != S_SEARCH) && (err_line || err_timeout || err_frame);

  always_comb begin
    state_nxt = state;
    case (state)
      S_SEARCH: if (vs_rise) state_nxt = S_TRACK;
      S_TRACK:  if (err) state_nxt = S_SEARCH; else if (vs_rise) state_nxt = S_LOCKED;
      S_LOCKED: if (err) state_nxt = S_SEARCH;
      default:  state_nxt = S_SEARCH;
    endcase
  end

  assign in_window = (h_pos_nxt >= H_FIRST) && (h_pos_nxt <= H_LAST) &&
                     (v_pos_nxt >= V_FIRST) && (v_pos_nxt <= V_LAST);
  assign valid_nxt = in_window && (state_nxt == S_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_pos          <= 11'd0;
      v_pos          <= 11'd0;
      hs_low         <= 11'd0;
      vs_low         <= 11'd0;
      state          <= S_SEARCH;
      bus.x_pix      <= 11'd0;
      bus.y_pix      <= 11'd0;
      bus.pix_valid  <= 1'b0;
      bus.pix_rgb    <= 3'b000;
      bus.err_sticky <= 1'b0;
      bus.err_cnt    <= 8'd0;
    end else begin
      h_pos <= h_pos_nxt;
      v_pos <= v_pos_nxt;
      if (hs_rise)                        hs_low <= 11'd0;
      else if (!hs_q && hs_low != POS_MAX) hs_low <= hs_low + 11'd1;
      if (vs_rise)                                   vs_low <= 11'd0;
      else if (hs_rise && !vs_q && vs_low != POS_MAX) vs_low <= vs_low + 11'd1;
      state         <= state_nxt;
      bus.x_pix     <= in_window ? (h_pos_nxt - H_FIRST) : 11'd0;
      bus.y_pix     <= in_window ? (v_pos_nxt - V_FIRST) : 11'd0;
      bus.pix_valid <= valid_nxt;
      bus.pix_rgb   <= valid_nxt ? rgb_q : 3'b000;
      if (err) begin
        bus.err_sticky <= 1'b1;
        if (bus.err_cnt != 8'hff) bus.err_cnt <= bus.err_cnt + 8'd1;
      end
    end
  end

  assign bus.lock = (state == S_LOCKED);

`ifdef VGA_RX_PIXCNT_EN
  logic [17:0] acc_r, acc_g, acc_b;
  logic        frame_ok;

  // A frame that ends in a timing error is discarded rather than published.
  assign frame_ok = vs_rise && (state == S_LOCKED) && !err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_r          <= 18'd0;
      acc_g          <= 18'd0;
      acc_b          <= 18'd0;
      bus.cnt_r      <= 18'd0;
      bus.cnt_g      <= 18'd0;
      bus.cnt_b      <= 18'd0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= frame_ok;
      if (frame_ok) begin
        bus.cnt_r <= acc_r;
        bus.cnt_g <= acc_g;
        bus.cnt_b <= acc_b;
      end
      if (vs_rise || state_nxt != S_LOCKED) begin
        acc_r <= 18'd0;
        acc_g <= 18'd0;
        acc_b <= 18'd0;
      end else if (valid_nxt) begin
        acc_r <= acc_r + {17'd0, rgb_q[2]};
        acc_g <= acc_g + {17'd0, rgb_q[1]};
        acc_b <= acc_b + {17'd0, rgb_q[0]};
      end
    end
  end
`else
  assign bus.frame_done = 1'b0;
  assign bus.cnt_r      = 18'd0;
  assign bus.cnt_g      = 18'd0;
  assign bus.cnt_b      = 18'd0;
`endif
endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb/tb_vga_rx_monitor.sv - self-checking bench for vga_rx_monitor on a reduced 40x20 raster
module tb_vga_rx_monitor;
  localparam int HT = 40, HS = 6, HAS = 9, HA = 24;
  localparam int VT = 20, VS = 3, VAS = 5, VA = 10;
  localparam int BUDGET = 2 * HT * VT;

  typedef struct {
    logic [2:0] sw;
    int         r;
    int         g;
    int         b;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_rx_monitor_if bus ();

  vga_rx_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_ACT_START(HAS), .H_ACTIVE(HA),
    .V_TOTAL(VT), .V_SYNC(VS), .V_ACT_START(VAS), .V_ACTIVE(VA)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  int         gen_h = 1, gen_v = 1, gen_col = 0, gen_row = 0;
  logic       gen_act = 1'b0;
  logic [2:0] gen_rgb = 3'b000;
  logic [2:0] sw = 3'b111;
  logic       stuck = 1'b0;
  int         short_cnt = 0, short_done = 0;

  logic       chk_en = 1'b0;
  logic       act_d1 = 1'b0, act_d2 = 1'b0;
  int         col_d1 = 0, col_d2 = 0, row_d1 = 0, row_d2 = 0;
  logic [2:0] rgb_d1 = 3'b000, rgb_d2 = 3'b000;
  int         tb_r = 0, tb_g = 0, tb_b = 0, fd_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Generator: line position 1 is the h_sync rising cycle, sync pulses sit at the end of line/frame.
  task automatic drive_pins();
    gen_act = (gen_h >= HAS) && (gen_h <= HAS + HA - 1) && (gen_v >= VAS) && (gen_v <= VAS + VA - 1);
    gen_col = gen_h - HAS;
    gen_row = gen_v - VAS;
    if (gen_act) gen_rgb = {sw[0] & (gen_col < 8), sw[1] & (gen_row % 2 == 0), sw[2]};
    else         gen_rgb = 3'b111;
    bus.h_sync = stuck ? 1'b1 : !(gen_h > HT - HS);
    bus.v_sync = stuck ? 1'b1 : !(gen_v > VT - VS);
    bus.R = gen_rgb[2];
    bus.G = gen_rgb[1];
    bus.B = gen_rgb[0];
  endtask

  initial begin : generator
    drive_pins();
    forever begin
      @(posedge clk);
      #1;
      if (gen_h >= ((short_done != short_cnt) ? HT - 1 : HT)) begin
        if (short_done != short_cnt) short_done++;
        gen_h = 1;
        gen_v = (gen_v == VT) ? 1 : gen_v + 1;
      end else begin
        gen_h++;
      end
      drive_pins();
    end
  end

  task automatic tick();
    logic [31:0] exp_s, act_s;
    @(negedge clk);
    if (chk_en) begin
      exp_s = {6'd0, act_d2, act_d2 ? rgb_d2 : 3'b000,
               act_d2 ? 11'(col_d2) : 11'd0, act_d2 ? 11'(row_d2) : 11'd0};
      act_s = {6'd0, bus.pix_valid, bus.pix_rgb, bus.x_pix, bus.y_pix};
      chk($sformatf("pix_stream h=%0d v=%0d", gen_h, gen_v), act_s, exp_s);
    end
    if (bus.pix_valid) begin
      tb_r += int'(bus.pix_rgb[2]);
      tb_g += int'(bus.pix_rgb[1]);
      tb_b += int'(bus.pix_rgb[0]);
    end
    if (bus.frame_done) fd_seen++;
    act_d2 = act_d1; col_d2 = col_d1; row_d2 = row_d1; rgb_d2 = rgb_d1;
    act_d1 = gen_act; col_d1 = gen_col; row_d1 = gen_row; rgb_d1 = gen_rgb;
  endtask

  task automatic wait_gen(input int h, input int v, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(gen_h == h && gen_v == v) && n < BUDGET);
    if (!(gen_h == h && gen_v == v)) begin
      checks++;
      errors++;
      $display("FAIL timeout_%s: actual=not reached required=h%0d v%0d", name, h, v);
    end
  endtask

  vec_t vecs[6];
  int sr, sg, sb;

  initial begin : main
    bit found;
    vecs[0] = '{3'b111, 80, 120, 240};
    vecs[1] = '{3'b001, 80, 0, 0};
    vecs[2] = '{3'b010, 0, 120, 0};
    vecs[3] = '{3'b100, 0, 0, 240};
    vecs[4] = '{3'b101, 80, 0, 240};
    vecs[5] = '{3'b000, 0, 0, 0};

    repeat (3) tick();
    chk("rst_lock", bus.lock, 0);
    chk("rst_err_sticky", bus.err_sticky, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_pix", {bus.pix_valid, bus.pix_rgb, bus.x_pix, bus.y_pix}, 0);
    chk("rst_cnt", {bus.frame_done, bus.cnt_r | bus.cnt_g | bus.cnt_b}, 0);

    wait_gen(HAS, 10, "rel");
    reset = 1'b0;
    wait_gen(1, 1, "f1");
    tick(); tick();
    chk("lock_after_first_vs", bus.lock, 0);
    wait_gen(1, 1, "f2");
    tick();
    chk("lock_before_rise", bus.lock, 0);
    tick();
    chk("lock_rise", bus.lock, 1);
    chk("clean_err_cnt", bus.err_cnt, 0);
    chk("clean_err_sticky", bus.err_sticky, 0);
    chk_en = 1'b1;

    wait_gen(HAS, VAS, "first_px");
    tick();
    chk("align_pre_valid", bus.pix_valid, 0);
    tick();
    chk("align_first", {bus.pix_valid, bus.pix_rgb, bus.x_pix, bus.y_pix}, {1'b1, 3'b111, 11'd0, 11'd0});
    wait_gen(HAS + HA - 1, VAS + VA - 1, "last_px");
    tick(); tick();
    chk("align_last", {bus.pix_valid, bus.pix_rgb, bus.x_pix, bus.y_pix}, {1'b1, 3'b001, 11'd23, 11'd9});
    tick();
    chk("align_after_last", {bus.pix_valid, bus.x_pix, bus.y_pix}, 0);

    wait_gen(1, 1, "vec_start");
    sw = vecs[0].sw;
    sr = tb_r; sg = tb_g; sb = tb_b;
    for (int i = 0; i < 6; i++) begin
      wait_gen(1, 1, "vec_end");
      chk($sformatf("vec%0d_stream_r", i), tb_r - sr, vecs[i].r);
      chk($sformatf("vec%0d_stream_g", i), tb_g - sg, vecs[i].g);
      chk($sformatf("vec%0d_stream_b", i), tb_b - sb, vecs[i].b);
      sr = tb_r; sg = tb_g; sb = tb_b;
      if (i < 5) sw = vecs[i + 1].sw;
`ifdef VGA_RX_PIXCNT_EN
      found = 1'b0;
      for (int k = 0; k < 8 && !found; k++) begin
        tick();
        found = bus.frame_done;
      end
      chk($sformatf("vec%0d_frame_done", i), found, 1);
      chk($sformatf("vec%0d_cnt_r", i), bus.cnt_r, vecs[i].r);
      chk($sformatf("vec%0d_cnt_g", i), bus.cnt_g, vecs[i].g);
      chk($sformatf("vec%0d_cnt_b", i), bus.cnt_b, vecs[i].b);
`else
      chk($sformatf("vec%0d_cnt_tied", i), {bus.cnt_r | bus.cnt_g | bus.cnt_b}, 0);
`endif
    end
    sw = 3'b111;
    chk_en = 1'b0;

    wait_gen(1, 8, "short_arm");
    short_cnt++;
    wait_gen(1, 9, "short_end");
    tick();
    chk("short_lock_hold", bus.lock, 1);
    tick();
    chk("short_lock_fall", bus.lock, 0);
    chk("short_err_sticky", bus.err_sticky, 1);
    chk("short_err_cnt", bus.err_cnt, 1);
    wait_gen(1, 1, "short_f1");
    tick(); tick();
    chk("short_track", bus.lock, 0);
    wait_gen(1, 1, "short_f2");
    tick(); tick();
    chk("short_relock", bus.lock, 1);
    chk("short_err_cnt_hold", bus.err_cnt, 1);

    wait_gen(2, 5, "stuck_arm");
    stuck = 1'b1;
    wait_gen(1, 6, "stuck_to");
    tick();
    chk("stuck_lock_hold", bus.lock, 1);
    tick();
    chk("stuck_lock_fall", bus.lock, 0);
    chk("stuck_err_cnt", bus.err_cnt, 2);
    repeat (2200) tick();
    chk("stuck_err_cnt_once", bus.err_cnt, 2);
    chk("stuck_lock_low", bus.lock, 0);
    wait_gen(2, 1, "stuck_rel");
    stuck = 1'b0;
    wait_gen(1, 1, "stuck_f1");
    wait_gen(1, 1, "stuck_f2");
    tick(); tick();
    chk("stuck_relock", bus.lock, 1);
    chk_en = 1'b1;

    wait_gen(HAS + 3, 12, "mid_rst");
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_lock", bus.lock, 0);
    chk("midrst_err", {bus.err_sticky, bus.err_cnt}, 0);
    chk("midrst_pix", {bus.pix_valid, bus.pix_rgb, bus.x_pix, bus.y_pix}, 0);
    chk("midrst_cnt", {bus.frame_done, bus.cnt_r | bus.cnt_g | bus.cnt_b}, 0);
    repeat (3) tick();
    reset = 1'b0;
    wait_gen(1, 1, "rr_f1");
    tick(); tick();
    chk("rr_track", bus.lock, 0);
    wait_gen(1, 1, "rr_f2");
    tick(); tick();
    chk("rr_relock", bus.lock, 1);
    chk("rr_err_cnt", bus.err_cnt, 0);
`ifndef VGA_RX_PIXCNT_EN
    chk("frame_done_tied", fd_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_rx_monitor.md
# vga_rx_monitor

- **Role:** receive-side counterpart of the VGA timing/pattern generator.
- **Inputs:** the generator's `h_sync`/`v_sync` (active low) and 1-bit `R`/`G`/`B`.
- **Function:** recovers pixel coordinates, checks sync timing against the 800×600 / 1040×666 raster, and locks after one clean frame.
- **Measurement:** once locked, counts lit pixels per colour per frame, for on-board self-check of the patterns.

## Interface
Parameters:
- `H_TOTAL`, 1040, clocks per line
- `H_SYNC`, 120, `h_sync` low width (clocks)
- `H_ACT_START`, 105, first active position (line position 1 = `h_sync` rising)
- `H_ACTIVE`, 800, active pixels per line
- `V_TOTAL`, 666, lines per frame
- `V_SYNC`, 8, `v_sync` low width (lines)
- `V_ACT_START`, 23, first active line (line 1 = `v_sync` rising)
- `V_ACTIVE`, 600, active lines

Ports:
- `clk` in 1, pixel clock
- `reset` in 1, asynchronous, active-high
- `h_sync` in 1, horizontal sync, active low
- `v_sync` in 1, vertical sync, active low
- `R` in 1, red input
- `G` in 1, green input
- `B` in 1, blue input
- `x_pix` out 11, recovered column, 0..799
- `y_pix` out 11, recovered row, 0..599
- `pix_valid` out 1, active pixel while locked
- `pix_rgb` out 3, {R,G,B} aligned to `x_pix`/`y_pix`
- `lock` out 1, timing locked
- `err_sticky` out 1, any timing error since reset
- `err_cnt` out 8, error count, saturates at 255
- `frame_done` out 1, one-cycle pulse when counts update
- `cnt_r` out 18, lit red pixels in last frame
- `cnt_g` out 18, lit green pixels in last frame
- `cnt_b` out 18, lit blue pixels in last frame

## Operation
- **Stage 1 (input register):** `hs_q`, `vs_q`, `rgb_q`. `hs_q`/`vs_q` reset to 1; `rgb_q` resets to 0. `hs_qq` delays `hs_q` by one cycle; `vs_qq` delays `vs_q` by one cycle.
- **Edge detects:** `hs_rise = hs_q & ~hs_qq`; `vs_rise = vs_q & ~vs_qq`.
- **h_pos (11 bit):**
  - Set to 1 on `hs_rise`; otherwise increments.
  - Saturates at 2047.
- **hs_low:** counts cycles with `hs_q == 0`; cleared on `hs_rise` after it is checked.
- **v_pos:**
  - Set to 1 when `vs_rise` and `hs_rise` occur in the same cycle.
  - Otherwise increments on each `hs_rise`; saturates at 2047.
- **vs_low:** counts lines with `vs_q == 0`; cleared on `vs_rise` after it is checked.
- **Lock FSM:**
  - SEARCH (reset state): on `vs_rise` → TRACK.
  - TRACK: on the next `vs_rise` with no error → LOCKED.
  - LOCKED: held while no error occurs.
- **Errors (TRACK or LOCKED only):**
  - At `hs_rise`: previous `h_pos` ≠ `H_TOTAL`, or `hs_low` ≠ `H_SYNC`.
  - Without `hs_rise`: `h_pos` reaches `H_TOTAL + 1`.
  - At `vs_rise`: previous `v_pos` ≠ `V_TOTAL`, or `vs_low` ≠ `V_SYNC`.
  - `vs_rise` without a coincident `hs_rise`.
- **On any error:** → SEARCH; `err_sticky` ← 1; `err_cnt` +1 (saturating). Errors in SEARCH are ignored.
- **Active window:** `h_pos` ∈ [`H_ACT_START`, `H_ACT_START + H_ACTIVE − 1`] and `v_pos` ∈ [`V_ACT_START`, `V_ACT_START + V_ACTIVE − 1`].
  - `x_pix = h_pos − H_ACT_START` and `y_pix = v_pos − V_ACT_START` inside the window; both 0 outside it.
  - `pix_valid = window & lock`. Outside `pix_valid`, `pix_rgb` = 0.
- **Accumulators (18 bit each):** add `rgb_q` bits when `pix_valid` would be asserted.
  - On `vs_rise` in LOCKED: copy accumulators to `cnt_*`, pulse `frame_done`, clear accumulators.
  - A clear on `vs_rise` takes precedence over an add in the same cycle.
  - Leaving LOCKED clears the accumulators; `cnt_*` hold their last values.

## Timing
- **Latency:** 2 cycles from pins to `x_pix`/`y_pix`/`pix_rgb`/`pix_valid` (input register, then output register).
- **Alignment:** the pixel the generator drives at H_scan = n appears with `x_pix = n − 105`.
- **lock:** rises 1 cycle after the second `vs_rise` following SEARCH. Falls 1 cycle after the erroring edge (or the timeout cycle).
- **frame_done / cnt_*:** `frame_done` and new `cnt_*` appear 1 cycle after the `vs_rise` detection.
- **Reset values:** all outputs 0, FSM in SEARCH.
- **Reset mid-frame:** takes effect immediately; re-lock requires two full frames.

## Configuration
- **`VGA_RX_PIXCNT_EN` defined:**
  - Accumulators, `cnt_r`/`cnt_g`/`cnt_b` and `frame_done` are implemented as described.
- **`VGA_RX_PIXCNT_EN` undefined:**
  - No accumulator logic is built.
  - `cnt_*` are tied to 0 and `frame_done` is tied to 0.
  - All other behaviour is unchanged.

## Test plan
- **Clean lock:** generator running, reset released → `lock` = 1 exactly 1 cycle after the 2nd `vs_rise`; `err_cnt` = 0.
- **Bar pattern, all colours on:** pattn = 001 with SW[2:0] = 111 → first `frame_done` after lock gives `cnt_r` = `cnt_g` = `cnt_b` = 240000.
- **Colour gating:** SW[2:0] = 001 → `cnt_r` = 240000, `cnt_g` = 0, `cnt_b` = 0.
- **Short line:** one line of 1039 clocks while locked → `lock` = 0 next cycle; `err_sticky` = 1; `err_cnt` = 1; re-lock after two clean frames.
- **Stuck sync:** `h_sync` held high → error when `h_pos` reaches 1041; `h_pos` saturates at 2047; `err_cnt` increments only once, since later cycles are in SEARCH.
- **Alignment and reset:**
  - Check `x_pix`/`y_pix` = (0,0) aligned with generator H_scan = 105, V_scan = 23, delayed 2 cycles.
  - Assert `reset` at line 300 → all outputs 0 immediately.
